// File: rtl/axis_fraction_pkg.sv
// Shared definitions for the fraction divider/multiplier family: width helpers,
// FSM state encoding and the bit order of the packed result tuser.
package axis_fraction_pkg;

  function automatic int msb(input int width);
    return (width > 0) ? width - 1 : 0;
  endfunction

  function automatic int min_width(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  function automatic int max_width(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // AXI4-Stream tdata buses are whole bytes wide.
  function automatic int align8(input int width);
    return ((width + 7) / 8) * 8;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Result tuser is {b_user, a_user, inexact}, with inexact at the LSB.
  localparam int USER_INEXACT_POS = 0;

  function automatic int a_user_lsb(input int inexact_bits);
    return inexact_bits;
  endfunction

  function automatic int b_user_lsb(input int inexact_bits, input int a_user_bits);
    return inexact_bits + a_user_bits;
  endfunction

endpackage

// File: rtl/fraction_shift_add_core.sv
// Serial shift-add datapath: consumes one bit of B per step and produces the
// rounded, fraction-dropped product plus an inexact flag on the final step.
module fraction_shift_add_core
  import axis_fraction_pkg::*;
#(
  parameter int A_WIDTH          = 48,
  parameter int B_WIDTH          = 32,
  parameter int FRACTIONAL_WIDTH = 16,
  parameter int ROUND_NEAREST    = 1,
  parameter int OUT_WIDTH        = A_WIDTH + B_WIDTH - FRACTIONAL_WIDTH
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 load,
  input  logic                 step,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] result,
  output logic                 inexact
);

  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int RND_POS = (FRACTIONAL_WIDTH > 0) ? FRACTIONAL_WIDTH - 1 : 0;
  localparam logic [PW-1:0] RND =
    (ROUND_NEAREST != 0 && FRACTIONAL_WIDTH > 0) ? (PW'(1) << RND_POS) : '0;
  localparam logic [PW-1:0] FRAC_MASK = (PW'(1) << FRACTIONAL_WIDTH) - PW'(1);
  localparam logic [B_WIDTH-1:0] LAST_STEP = B_WIDTH'(B_WIDTH - 1);

  logic [A_WIDTH-1:0] a_q;
  logic [B_WIDTH-1:0] b_sr;
  logic [B_WIDTH-1:0] cnt;
  logic [PW-1:0]      acc;

  logic [A_WIDTH:0]   partial;
  logic [PW-1:0]      acc_next;
  logic [PW-1:0]      rounded;

  // The upper A bits accumulate partial sums; the lower B bits collect the
  // product LSBs as they shift out, so after B_WIDTH steps acc holds A*B.
  always_comb begin
    partial  = {1'b0, acc[PW-1:B_WIDTH]} + (b_sr[0] ? {1'b0, a_q} : '0);
    acc_next = PW'({partial, acc[B_WIDTH-1:0]} >> 1);
    rounded  = acc_next + RND;
    done     = step && (cnt == LAST_STEP);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      a_q     <= '0;
      b_sr    <= '0;
      cnt     <= '0;
      acc     <= '0;
      result  <= '0;
      inexact <= 1'b0;
    end else if (load) begin
      a_q  <= a;
      b_sr <= b;
      cnt  <= '0;
      acc  <= '0;
    end else if (step) begin
      acc  <= acc_next;
      b_sr <= b_sr >> 1;
      cnt  <= cnt + B_WIDTH'(1);
      if (done) begin
        result  <= OUT_WIDTH'(rounded >> FRACTIONAL_WIDTH);
        inexact <= |(acc_next & FRAC_MASK);
      end
    end
  end

endmodule

// File: rtl/axis_fraction_multiplier.sv
// AXI4-Stream fixed-point multiplier: (A*B) >> FRACTIONAL_WIDTH with optional
// round-to-nearest, one operation in flight, full output backpressure.
module axis_fraction_multiplier
  import axis_fraction_pkg::*;
#(
  parameter int A_WIDTH          = 48,
  parameter int B_WIDTH          = 32,
  parameter int FRACTIONAL_WIDTH = 16,
  parameter int A_USER_WIDTH     = 0,
  parameter int B_USER_WIDTH     = 0,
  parameter int ROUND_NEAREST    = 1,
  parameter int DETECT_INEXACT   = 1
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic aclken,

  input  logic                                  s_axis_a_tvalid,
  output logic                                  s_axis_a_tready,
  input  logic [msb(align8(A_WIDTH)):0]         s_axis_a_tdata,
  input  logic [msb(max_width(A_USER_WIDTH, 1)):0] s_axis_a_tuser,

  input  logic                                  s_axis_b_tvalid,
  output logic                                  s_axis_b_tready,
  input  logic [msb(align8(B_WIDTH)):0]         s_axis_b_tdata,
  input  logic [msb(max_width(B_USER_WIDTH, 1)):0] s_axis_b_tuser,

  output logic                                  m_axis_dout_tvalid,
  input  logic                                  m_axis_dout_tready,
  output logic [msb(align8(A_WIDTH + B_WIDTH - FRACTIONAL_WIDTH)):0] m_axis_dout_tdata,
  output logic [msb(max_width(DETECT_INEXACT + A_USER_WIDTH + B_USER_WIDTH, 1)):0]
                                                m_axis_dout_tuser
);

  localparam int OUT_WIDTH  = A_WIDTH + B_WIDTH - FRACTIONAL_WIDTH;
  localparam int OUT_DATA_W = align8(OUT_WIDTH);
  localparam int DI         = (DETECT_INEXACT != 0) ? 1 : 0;
  localparam int AU_W       = max_width(A_USER_WIDTH, 1);
  localparam int BU_W       = max_width(B_USER_WIDTH, 1);

  state_t state, state_next;

  logic                 load;
  logic                 step;
  logic                 done;
  logic [OUT_WIDTH-1:0] result;
  logic                 inexact;
  logic [AU_W-1:0]      a_user_q;
  logic [BU_W-1:0]      b_user_q;

  // Padding bits of the byte-aligned buses and zero-width user ports carry nothing.
  logic unused_inputs;
  assign unused_inputs = ^{s_axis_a_tdata, s_axis_b_tdata,
                           s_axis_a_tuser, s_axis_b_tuser, inexact};

  // NOTE: the reset is synchronous and not qualified by aclken, so the block
  // always drops back to IDLE while aresetn is low.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
    end else if (aclken) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next         = state;
    s_axis_a_tready    = 1'b0;
    s_axis_b_tready    = 1'b0;
    m_axis_dout_tvalid = 1'b0;
    load               = 1'b0;
    step               = 1'b0;
    case (state)
      IDLE: begin
        // Each ready follows the other channel's valid: both operands or neither.
        s_axis_a_tready = s_axis_b_tvalid & aclken & aresetn;
        s_axis_b_tready = s_axis_a_tvalid & aclken & aresetn;
        load            = s_axis_a_tvalid & s_axis_b_tvalid & aclken & aresetn;
        if (load) state_next = MUL;
      end
      MUL: begin
        step = aclken;
        if (done) state_next = OUT;
      end
      OUT: begin
        m_axis_dout_tvalid = 1'b1;
        if (m_axis_dout_tready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      a_user_q <= '0;
      b_user_q <= '0;
    end else if (load) begin
      a_user_q <= s_axis_a_tuser;
      b_user_q <= s_axis_b_tuser;
    end
  end

  fraction_shift_add_core #(
    .A_WIDTH         (A_WIDTH),
    .B_WIDTH         (B_WIDTH),
    .FRACTIONAL_WIDTH(FRACTIONAL_WIDTH),
    .ROUND_NEAREST   (ROUND_NEAREST),
    .OUT_WIDTH       (OUT_WIDTH)
  ) u_core (
    .aclk   (aclk),
    .aresetn(aresetn),
    .load   (load),
    .step   (step),
    .a      (s_axis_a_tdata[A_WIDTH-1:0]),
    .b      (s_axis_b_tdata[B_WIDTH-1:0]),
    .done   (done),
    .result (result),
    .inexact(inexact)
  );

  assign m_axis_dout_tdata = OUT_DATA_W'(result);

  always_comb begin
    m_axis_dout_tuser = '0;
    if (DI != 0) m_axis_dout_tuser[USER_INEXACT_POS] = inexact;
    for (int i = 0; i < A_USER_WIDTH; i++)
      m_axis_dout_tuser[a_user_lsb(DI) + i] = a_user_q[i];
    for (int i = 0; i < B_USER_WIDTH; i++)
      m_axis_dout_tuser[b_user_lsb(DI, A_USER_WIDTH) + i] = b_user_q[i];
  end

endmodule
